// File: rtl/bus_bridge.sv
// Single-outstanding CPU-to-device bridge: decodes addr to N_SLV channels, holds strobes until ready or timeout.
// Latency: 2 cycles for a zero-wait device, +1 per device wait cycle; decode error / null access respond in 1 cycle.
// Backpressure: m_req is only sampled in IDLE and never queued; devices stall by holding s_ready low up to TIMEOUT cycles.
module bus_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int N_SLV   = 4,
   parameter int DEC_LSB = 28,
   parameter int TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          m_req,
   input  logic [ADDR_W-1:0]             m_addr,
   input  logic [DATA_W-1:0]             m_wdata,
   input  logic                          m_r,
   input  logic [DATA_W/8-1:0]           m_w,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          m_ready,
   output logic                          m_err,
   output logic                          m_busy,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [N_SLV-1:0]              s_r,
   output logic [(DATA_W/8)*N_SLV-1:0]   s_w,
   input  logic [DATA_W*N_SLV-1:0]       s_rdata,
   input  logic [N_SLV-1:0]              s_ready
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDX_W:0]   N_SLV_L   = (IDX_W+1)'(N_SLV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic             rd;
      logic [IDX_W-1:0] idx;
   } req_t;

   state_t           state;
   req_t             req_q;
   logic [CNT_W-1:0] cnt;

   logic [IDX_W-1:0]  dec_idx;
   logic              dec_bad;
   logic              dec_null;
   logic              sel_rdy;
   logic [DATA_W-1:0] sel_dat;

   always_comb begin
      dec_idx  = m_addr[DEC_LSB +: IDX_W];
      dec_bad  = ({1'b0, dec_idx} >= N_SLV_L) || (m_r && (m_w != '0));
      dec_null = !m_r && (m_w == '0);
   end

   // Only the latched channel's ready/data are observed; others are ignored.
   always_comb begin
      sel_rdy = 1'b0;
      sel_dat = '0;
      for (int k = 0; k < N_SLV; k++) begin
         if (req_q.idx == IDX_W'(k)) begin
            sel_rdy = s_ready[k];
            sel_dat = s_rdata[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         req_q   <= '0;
         cnt     <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_r     <= '0;
         s_w     <= '0;
         m_rdata <= '0;
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         m_busy  <= 1'b0;
      end else begin
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (m_req) begin
                  s_addr    <= m_addr;
                  s_wdata   <= m_wdata;
                  req_q.rd  <= m_r;
                  req_q.idx <= dec_idx;
                  m_busy    <= 1'b1;
                  if (dec_bad) begin
                     state   <= RESP;
                     m_ready <= 1'b1;
                     m_err   <= 1'b1;
                     if (m_r) m_rdata <= '0;
                  end else if (dec_null) begin
                     state   <= RESP;
                     m_ready <= 1'b1;
                  end else begin
                     state <= ACCESS;
                     cnt   <= '0;
                     for (int k = 0; k < N_SLV; k++) begin
                        if (dec_idx == IDX_W'(k)) begin
                           s_r[k]               <= m_r;
                           s_w[k*BE_W +: BE_W] <= m_w;
                        end
                     end
                  end
               end
            end
            ACCESS: begin
               // Ready on the final allowed cycle takes priority over timeout.
               if (sel_rdy) begin
                  state   <= RESP;
                  m_ready <= 1'b1;
                  s_r     <= '0;
                  s_w     <= '0;
                  if (req_q.rd) m_rdata <= sel_dat;
               end else if (cnt == CNT_LAST) begin
                  state   <= RESP;
                  m_ready <= 1'b1;
                  m_err   <= 1'b1;
                  s_r     <= '0;
                  s_w     <= '0;
                  if (req_q.rd) m_rdata <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               state  <= IDLE;
               m_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               m_busy <= 1'b0;
               s_r    <= '0;
               s_w    <= '0;
            end
         endcase
      end
   end

endmodule
